// File: rtl/timer_bcd_param_pkg.sv
// rtl/timer_bcd_param_pkg.sv - shared state encodings and BCD digit limits for the mm:ss timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

endpackage

// File: rtl/timer_bcd_param_digit.sv
// rtl/timer_bcd_param_digit.sv - one BCD digit with saturating load and up/down step
module bcd_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] q,
  output logic       term
);

  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (ld_val > MAX) ? MAX : ld_val;
    end else if (en) begin
      if (up) q_d = (q_q == MAX)  ? 4'd0 : q_q + 4'd1;
      else    q_d = (q_q == 4'd0) ? MAX  : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) q_q <= 4'd0;
    else       q_q <= q_d;
  end

  assign q    = q_q;
  assign term = up ? (q_q == MAX) : (q_q == 4'd0);

endmodule

// File: rtl/timer_bcd_param.sv
// rtl/timer_bcd_param.sv - mm:ss BCD timer with run/pause/done control and terminal saturation
module timer_bcd_param
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        tick,
  input  logic                        load,
  input  logic [4*(MIN_DIGITS+2)-1:0] data,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        up,
  output logic [3:0]                  so,
  output logic [3:0]                  st,
  output logic [4*MIN_DIGITS-1:0]     mins,
  output logic                        zero,
  output logic                        done,
  output logic                        running,
  output logic [1:0]                  state
);

  localparam int N = MIN_DIGITS + 2;

  state_e         state_q, state_d;
  logic           dir_q, dir_d;
  logic           done_q, done_d;
  logic           running_q;
  logic [4*N-1:0] qv;
  logic [N-1:0]   term, en, is_zero, is_max;
  logic           ld_acc, count_en, hit, full, start_ok;

  // Digit 0 = seconds units, 1 = seconds tens, 2.. = minutes LSD upward.
  for (genvar i = 0; i < N; i++) begin : g_digit
    localparam logic [3:0] DMAX = (i == 1) ? BCD_MAX_TENS : BCD_MAX_UNITS;

    if (i == 0) begin : g_en0
      assign en[i] = count_en;
    end else begin : g_enn
      assign en[i] = count_en & (&term[i-1:0]);
    end

    bcd_digit #(.MAX(DMAX)) u_digit (
      .clk   (clk),
      .clear (clear),
      .load  (ld_acc),
      .ld_val(data[4*i +: 4]),
      .en    (en[i]),
      .up    (dir_q),
      .q     (qv[4*i +: 4]),
      .term  (term[i])
    );

    assign is_zero[i] = (qv[4*i +: 4] == 4'd0);
    assign is_max[i]  = (qv[4*i +: 4] == DMAX);
  end

  assign zero     = &is_zero;
  assign full     = &is_max;
  assign count_en = (state_q == ST_RUN) && tick && !stop;
  // The tick that lands on the terminal value: every higher digit already terminal, units one step away.
  assign hit      = count_en && (&term[N-1:1]) &&
                    (dir_q ? (qv[3:0] == 4'd8) : (qv[3:0] == 4'd1));
  assign start_ok = start && (state_q == ST_IDLE || state_q == ST_PAUSE) &&
                    !(up ? full : zero);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    ld_acc  = 1'b0;
    if (load && state_q != ST_RUN) begin
      ld_acc  = 1'b1;
      state_d = ST_IDLE;
    end else if (stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (start_ok) begin
      state_d = ST_RUN;
      dir_d   = up;
    end else if (hit) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= ST_IDLE;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign so      = qv[3:0];
  assign st      = qv[7:4];
  assign mins    = qv[4*N-1:8];
  assign done    = done_q;
  assign running = running_q;
  assign state   = state_q;

endmodule

// File: doc/timer_bcd_param.md
Name: timer_bcd_param

Overview:
- Parametrised BCD countdown/count-up timer in the mm:ss format.
- Has a configurable number of minute digits.
- Adds start/stop control, a run/pause/done state machine, a direction mode, terminal saturation and a one-cycle done pulse.
- Sits behind the keypad/preset logic and drives the 7-segment display decoders and the end-of-cycle alarm.

Parameters:
- MIN_DIGITS, 2, number of BCD minute digits (legal range 1..3; max display 9:59 / 99:59 / 999:59).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle count-enable strobe (1 Hz from prescaler).
- load  in  1  load preset from data.
- data  in  4*(MIN_DIGITS+2)  BCD preset, packed {mins (MSD first), st, so}.
- start  in  1  start/resume request.
- stop  in  1  pause request.
- up  in  1  direction select: 1 = count up, 0 = count down; sampled on an accepted start.
- so  out  4  seconds units digit (0..9).
- st  out  4  seconds tens digit (0..5).
- mins  out  4*MIN_DIGITS  minute digits, MSD first.
- zero  out  1  combinational: high when every digit is 0.
- done  out  1  registered one-cycle pulse on reaching the terminal value.
- running  out  1  high while state = RUN.
- state  out  2  current FSM state (debug/status).

Behaviour:
- Reset: clear=1 at a rising edge takes priority over everything. Result: all digits 0, dir=down, state IDLE, done=0, running=0, zero=1.
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Priority within a cycle is clear > load > stop > start > tick.
- Load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Digits are written on the same edge; state goes to IDLE.
  - Sanitising: any units/minute digit >9 loads as 9; st >5 loads as 5.
- Start:
  - Accepted in IDLE or PAUSE; on acceptance, dir <= up and state goes to RUN.
  - Rejected (state unchanged) when the counter is already at the terminal value for the requested direction:
    - down: all zero;
    - up: all minute digits 9, st=5, so=9.
  - Ignored in DONE until a load occurs.
  - A tick in the same cycle as an accepted start is not counted.
- Stop:
  - RUN -> PAUSE with digits held; ignored elsewhere.
  - stop and start together in RUN: stop wins.
  - stop and tick together: no count.
- Counting (RUN and tick=1 only): ripple through a carry/borrow chain so -> st -> mins LSD -> ... -> MSD.
  - Down: so 0->9 with borrow; st 0->5 with borrow; minute digits 0->9 with borrow.
  - Up: so 9->0 with carry; st 5->0 with carry; minute digits 9->0 with carry.
  - Digits update on the same edge as the tick, i.e. latency 1 clock from tick to outputs.
- Terminal:
  - The tick that produces the terminal value also moves the state to DONE and sets done=1 for exactly one cycle.
  - Digits hold the terminal value; no wrap-around ever occurs.
  - In DONE, ticks are ignored and done stays 0 after its pulse.
- running tracks RUN registered. zero is combinational from the digit registers.
- clear mid-run: the next edge gives the reset values; a pending done pulse is suppressed.

Decomposition:
- Package timer_pkg holds:
  - state encodings IDLE/RUN/PAUSE/DONE (2-bit);
  - BCD_MAX_UNITS=9, BCD_MAX_TENS=5.
- One natural sub-module, bcd_digit:
  - parameter MAX (9 or 5);
  - inputs: clk, clear, load, ld_val, en, up;
  - outputs: q, term (q==MAX when up, q==0 when down).
  - Sanitises load to MAX. Instantiated MIN_DIGITS+2 times via generate.
- The chain enable is en_i = tick_run & term of all lower digits.

Test Plan:
- Reset: assert clear for 1 cycle mid-RUN at 03:27 -> next cycle digits 00:00, state=0, zero=1, running=0, done=0.
- Load + down count: load 01:02, start (up=0), 3 ticks -> 01:01, 01:00, 00:59. Keep ticking -> at 00:00, done=1 for one cycle, state=DONE; further ticks leave 00:00.
- Up count with saturation (MIN_DIGITS=2): load 99:58, start up=1, 2 ticks -> 99:59, done pulse, state=DONE; a 3rd tick leaves 99:59.
- Pause/resume and priority: in RUN at 00:10, assert stop+start+tick together -> state=PAUSE, value 00:10. start -> RUN; a same-cycle tick is not counted; the next tick gives 00:09.
- Load sanitising and RUN lockout: load data with st=7, so=12 -> st=5, so=9. A load during RUN with another value -> ignored, digits unchanged.
- Start rejection: load 00:00, start up=0 -> state stays IDLE, done never asserts. Then start up=1 -> RUN and the first tick gives 00:01.
